ex_stage: RTL and testbench

Execute stage of the 32-bit lapido pipelined core, between the decode stage and the memory stage. It evaluates the ALU operation on register/immediate operands and produces condition flags. It also resolves the register-file destination and the absolute jump target. All results and the forwarded control signals are captured in the EX/MEM pipeline register.

---
 rtl/ex_stage_pkg.sv | 29 ++
 rtl/ex_stage_alu.sv | 72 +++++++
 rtl/ex_stage.sv | 139 +++++++++++++
 tb/tb_ex_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg
//   Shared constants for the lapido execute stage: core PC width, ALU
//   function encodings and the bit positions inside the 6-bit flag vector.
package ex_stage_pkg;

  localparam int LAPIDO_PC_WIDTH = 32;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_PASSB = 6'h3F;

  localparam int FLAG_ZERO    = 0;
  localparam int FLAG_TRUE    = 1;
  localparam int FLAG_NEG     = 2;
  localparam int FLAG_NEGZERO = 3;
  localparam int FLAG_CARRY   = 4;
  localparam int FLAG_OVF     = 5;

  typedef logic [5:0] flags_t;

endpackage

// File: rtl/ex_stage_alu.sv
// ex_stage_alu
//   Combinational 32-bit ALU for the execute stage.
//   Ports:
//     a_i, b_i   operands (A = rs, B = rt or immediate)
//     funct_i    FN_* operation code
//     result_o   operation result
//     flags_o    {ovf, carry, negzero, neg, true, zero}
//   Build option: EX_SHIFT_EN enables SLL/SRL/SRA; without it those
//   codes fall into the default arm and no shifter is built.
module ex_stage_alu
  import ex_stage_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [5:0]  funct_i,
  output logic [31:0] result_o,
  output flags_t      flags_o
);

  logic [32:0] sum;
  logic [32:0] diff;
  logic [31:0] result;
  logic        carry;
  logic        ovf;

  // 33-bit forms expose carry-out / borrow in bit 32.
  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} - {1'b0, b_i};

  always_comb begin
    result = 32'd0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (funct_i)
      FN_ADD: begin
        result = sum[31:0];
        carry  = sum[32];
        ovf    = (a_i[31] == b_i[31]) && (sum[31] != a_i[31]);
      end
      FN_SUB: begin
        result = diff[31:0];
        carry  = diff[32];  // borrow: A < B unsigned
        ovf    = (a_i[31] != b_i[31]) && (diff[31] != a_i[31]);
      end
      FN_AND:   result = a_i & b_i;
      FN_OR:    result = a_i | b_i;
      FN_XOR:   result = a_i ^ b_i;
      FN_NOR:   result = ~(a_i | b_i);
      FN_SLT:   result = {31'd0, ($signed(a_i) < $signed(b_i))};
      FN_PASSB: result = b_i;
`ifdef EX_SHIFT_EN
      FN_SLL:   result = a_i << b_i[4:0];
      FN_SRL:   result = a_i >> b_i[4:0];
      FN_SRA:   result = $unsigned($signed(a_i) >>> b_i[4:0]);
`endif
      default: begin
        result = 32'd0;
        carry  = 1'b0;
        ovf    = 1'b0;
      end
    endcase
  end

  assign result_o               = result;
  assign flags_o[FLAG_ZERO]     = (result == 32'd0);
  assign flags_o[FLAG_TRUE]     = 1'b1;
  assign flags_o[FLAG_NEG]      = result[31];
  assign flags_o[FLAG_NEGZERO]  = result[31] | (result == 32'd0);
  assign flags_o[FLAG_CARRY]    = carry;
  assign flags_o[FLAG_OVF]      = ovf;

endmodule

// File: rtl/ex_stage.sv
// ex_stage
//   Execute stage of the lapido core: operand-B mux, ALU, destination and
//   jump-target muxes, all captured in the EX/MEM pipeline register.
//   Ports:
//     clk, rst (async, active low)
//     decode-side: alu_src_mux, alu_funct, reg_dst_mux, sel_j_jr, in_*
//     memory-side: out_* control copies, abs_addr, mem_addr, mem_data,
//                  alu_out, alu_flags_out, flag_addr, reg_dst
//   Build option: EX_SHIFT_EN (forwarded to the ALU shift operations).
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int PC_WIDTH = LAPIDO_PC_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_src_mux,
  input  logic [5:0]          alu_funct,
  input  logic [1:0]          reg_dst_mux,
  input  logic                sel_j_jr,
  input  logic [PC_WIDTH-1:0] in_next_pc,
  input  logic [31:0]         in_immediate,
  input  logic [31:0]         in_data_rs,
  input  logic [31:0]         in_data_rt,
  input  logic [4:0]          in_rs,
  input  logic [4:0]          in_rt,
  input  logic [4:0]          in_rd,
  input  logic                in_mem_write_enable,
  input  logic                in_sel_beq_bne,
  input  logic                in_fl_write_enable,
  input  logic                in_sel_jt_jf,
  input  logic                in_is_branch,
  input  logic                in_is_jump,
  input  logic                in_reg_write_enable,
  input  logic [1:0]          in_wb_res_mux,
  output logic                out_mem_write_enable,
  output logic                out_sel_beq_bne,
  output logic                out_fl_write_enable,
  output logic                out_sel_jt_jf,
  output logic                out_is_branch,
  output logic                out_is_jump,
  output logic                out_reg_write_enable,
  output logic [1:0]          out_wb_res_mux,
  output logic [PC_WIDTH-1:0] out_next_pc,
  output logic [31:0]         out_immediate,
  output logic [31:0]         abs_addr,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_data,
  output logic [31:0]         alu_out,
  output logic [5:0]          alu_flags_out,
  output logic [4:0]          flag_addr,
  output logic [4:0]          reg_dst
);

  logic [31:0] operand_b_d;
  logic [31:0] alu_res_d;
  flags_t      flags_d;
  logic [4:0]  reg_dst_d;
  logic [31:0] abs_addr_d;
  logic [8:0]  ctrl_d;

  logic [31:0]         alu_res_q;
  flags_t              flags_q;
  logic [31:0]         abs_addr_q;
  logic [31:0]         mem_data_q;
  logic [4:0]          reg_dst_q;
  logic [4:0]          flag_addr_q;
  logic [PC_WIDTH-1:0] next_pc_q;
  logic [31:0]         imm_q;
  logic [8:0]          ctrl_q;

  assign operand_b_d = alu_src_mux ? in_immediate : in_data_rt;
  assign abs_addr_d  = sel_j_jr ? in_data_rs : in_immediate;

  always_comb begin
    reg_dst_d = 5'd0;
    case (reg_dst_mux)
      2'b00:   reg_dst_d = in_rt;
      2'b01:   reg_dst_d = in_rd;
      2'b10:   reg_dst_d = 5'd31;  // link register
      default: reg_dst_d = 5'd0;
    endcase
  end

  // Forwarded controls travel as one bundle through the pipeline register.
  assign ctrl_d = {in_mem_write_enable, in_sel_beq_bne, in_fl_write_enable,
                   in_sel_jt_jf, in_is_branch, in_is_jump,
                   in_reg_write_enable, in_wb_res_mux};

  ex_stage_alu u_alu (
    .a_i      (in_data_rs),
    .b_i      (operand_b_d),
    .funct_i  (alu_funct),
    .result_o (alu_res_d),
    .flags_o  (flags_d)
  );

  // rs index is not consumed past decode; kept on the port for symmetry.
  logic unused_rs;
  assign unused_rs = ^in_rs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_res_q   <= 32'd0;
      flags_q     <= '0;   // true bit included: reads 0 in reset
      abs_addr_q  <= 32'd0;
      mem_data_q  <= 32'd0;
      reg_dst_q   <= 5'd0;
      flag_addr_q <= 5'd0;
      next_pc_q   <= '0;
      imm_q       <= 32'd0;
      ctrl_q      <= 9'd0;
    end else begin
      alu_res_q   <= alu_res_d;
      flags_q     <= flags_d;
      abs_addr_q  <= abs_addr_d;
      mem_data_q  <= in_data_rt;
      reg_dst_q   <= reg_dst_d;
      flag_addr_q <= in_rt;
      next_pc_q   <= in_next_pc;
      imm_q       <= in_immediate;
      ctrl_q      <= ctrl_d;
    end
  end

  assign alu_out       = alu_res_q;
  assign mem_addr      = alu_res_q;
  assign alu_flags_out = flags_q;
  assign abs_addr      = abs_addr_q;
  assign mem_data      = mem_data_q;
  assign reg_dst       = reg_dst_q;
  assign flag_addr     = flag_addr_q;
  assign out_next_pc   = next_pc_q;
  assign out_immediate = imm_q;
  assign {out_mem_write_enable, out_sel_beq_bne, out_fl_write_enable,
          out_sel_jt_jf, out_is_branch, out_is_jump,
          out_reg_write_enable, out_wb_res_mux} = ctrl_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage
//   Scoreboard bench for ex_stage: stimulus pushes hand-computed
//   expectations, a monitor pops one per clock after the capture edge.
//   Honours EX_SHIFT_EN for the shift vectors.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic        alu_src_mux;
  logic [5:0]  alu_funct;
  logic [1:0]  reg_dst_mux;
  logic        sel_j_jr;
  logic [31:0] in_next_pc;
  logic [31:0] in_immediate;
  logic [31:0] in_data_rs;
  logic [31:0] in_data_rt;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic        in_mem_write_enable, in_sel_beq_bne, in_fl_write_enable;
  logic        in_sel_jt_jf, in_is_branch, in_is_jump, in_reg_write_enable;
  logic [1:0]  in_wb_res_mux;
  logic        out_mem_write_enable, out_sel_beq_bne, out_fl_write_enable;
  logic        out_sel_jt_jf, out_is_branch, out_is_jump, out_reg_write_enable;
  logic [1:0]  out_wb_res_mux;
  logic [31:0] out_next_pc;
  logic [31:0] out_immediate;
  logic [31:0] abs_addr, mem_addr, mem_data, alu_out;
  logic [5:0]  alu_flags_out;
  logic [4:0]  flag_addr, reg_dst;

  ex_stage #(.PC_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .alu_src_mux(alu_src_mux), .alu_funct(alu_funct),
    .reg_dst_mux(reg_dst_mux), .sel_j_jr(sel_j_jr),
    .in_next_pc(in_next_pc), .in_immediate(in_immediate),
    .in_data_rs(in_data_rs), .in_data_rt(in_data_rt),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_mem_write_enable(in_mem_write_enable), .in_sel_beq_bne(in_sel_beq_bne),
    .in_fl_write_enable(in_fl_write_enable), .in_sel_jt_jf(in_sel_jt_jf),
    .in_is_branch(in_is_branch), .in_is_jump(in_is_jump),
    .in_reg_write_enable(in_reg_write_enable), .in_wb_res_mux(in_wb_res_mux),
    .out_mem_write_enable(out_mem_write_enable), .out_sel_beq_bne(out_sel_beq_bne),
    .out_fl_write_enable(out_fl_write_enable), .out_sel_jt_jf(out_sel_jt_jf),
    .out_is_branch(out_is_branch), .out_is_jump(out_is_jump),
    .out_reg_write_enable(out_reg_write_enable), .out_wb_res_mux(out_wb_res_mux),
    .out_next_pc(out_next_pc), .out_immediate(out_immediate),
    .abs_addr(abs_addr), .mem_addr(mem_addr), .mem_data(mem_data),
    .alu_out(alu_out), .alu_flags_out(alu_flags_out),
    .flag_addr(flag_addr), .reg_dst(reg_dst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] alu;
    logic [5:0]  flags;
    logic [31:0] abs_a;
    logic [31:0] mdata;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rdst;
    logic [4:0]  faddr;
    logic [8:0]  ctrl;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] out_ctrl();
    return {out_mem_write_enable, out_sel_beq_bne, out_fl_write_enable,
            out_sel_jt_jf, out_is_branch, out_is_jump,
            out_reg_write_enable, out_wb_res_mux};
  endfunction

  // Drive one instruction (no clock wait) and queue what the EX/MEM
  // register must hold after the next rising edge.
  // abs/mem_data/pc/imm/ctrl/flag_addr expectations are the chosen
  // stimulus values themselves, given explicitly.
  task automatic drive(input string nm, input logic src, input logic [5:0] fn,
                       input logic [1:0] rdm, input logic jr,
                       input logic [31:0] rs_v, input logic [31:0] rt_v,
                       input logic [31:0] imm_v,
                       input logic [31:0] exp_alu, input logic [5:0] exp_fl,
                       input logic [4:0] exp_rd, input logic [31:0] exp_abs);
    exp_t e;
    logic [8:0]  c;
    logic [31:0] pc_v;
    c    = 9'($urandom);
    pc_v = $urandom;
    alu_src_mux  = src;
    alu_funct    = fn;
    reg_dst_mux  = rdm;
    sel_j_jr     = jr;
    in_next_pc   = pc_v;
    in_immediate = imm_v;
    in_data_rs   = rs_v;
    in_data_rt   = rt_v;
    in_rs        = 5'd9;
    in_rt        = 5'd3;
    in_rd        = 5'd7;
    {in_mem_write_enable, in_sel_beq_bne, in_fl_write_enable, in_sel_jt_jf,
     in_is_branch, in_is_jump, in_reg_write_enable, in_wb_res_mux} = c;
    e.name  = nm;
    e.alu   = exp_alu;
    e.flags = exp_fl;
    e.abs_a = exp_abs;
    e.mdata = rt_v;
    e.pc    = pc_v;
    e.imm   = imm_v;
    e.rdst  = exp_rd;
    e.faddr = 5'd3;
    e.ctrl  = c;
    sb.push_back(e);
  endtask

  // Monitor: the stage produces a result every cycle; compare one queued
  // expectation per edge.
  initial begin
    exp_t e;
    int b0;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e  = sb.pop_front();
        b0 = bad;
        chk({e.name, ".alu_out"},  alu_out, e.alu);
        chk({e.name, ".mem_addr"}, mem_addr, e.alu);
        chk({e.name, ".flags"},    {26'd0, alu_flags_out}, {26'd0, e.flags});
        chk({e.name, ".abs_addr"}, abs_addr, e.abs_a);
        chk({e.name, ".mem_data"}, mem_data, e.mdata);
        chk({e.name, ".reg_dst"},  {27'd0, reg_dst}, {27'd0, e.rdst});
        chk({e.name, ".flag_addr"},{27'd0, flag_addr}, {27'd0, e.faddr});
        chk({e.name, ".ctrl"},     {23'd0, out_ctrl()}, {23'd0, e.ctrl});
        chk({e.name, ".next_pc"},  out_next_pc, e.pc);
        chk({e.name, ".imm"},      out_immediate, e.imm);
        $display("txn %s alu=%h flags=%b new_errors=%0d", e.name, alu_out, alu_flags_out, bad - b0);
      end
    end
  end

  task automatic chk_all_zero(input string nm);
    chk({nm, ".alu_out"},  alu_out, 32'd0);
    chk({nm, ".mem_addr"}, mem_addr, 32'd0);
    chk({nm, ".flags"},    {26'd0, alu_flags_out}, 32'd0);
    chk({nm, ".abs_addr"}, abs_addr, 32'd0);
    chk({nm, ".mem_data"}, mem_data, 32'd0);
    chk({nm, ".reg_dst"},  {27'd0, reg_dst}, 32'd0);
    chk({nm, ".flag_addr"},{27'd0, flag_addr}, 32'd0);
    chk({nm, ".ctrl"},     {23'd0, out_ctrl()}, 32'd0);
    chk({nm, ".next_pc"},  out_next_pc, 32'd0);
    chk({nm, ".imm"},      out_immediate, 32'd0);
  endtask

  logic [31:0] sra_exp, sll_exp, srl_exp;
  logic [5:0]  sra_fl, sll_fl, srl_fl;

  initial begin
`ifdef EX_SHIFT_EN
    sra_exp = 32'hF8000000; sra_fl = 6'b001110;
    sll_exp = 32'h00000010; sll_fl = 6'b000010;
    srl_exp = 32'h08000000; srl_fl = 6'b000010;
`else
    sra_exp = 32'h0; sra_fl = 6'b001011;
    sll_exp = 32'h0; sll_fl = 6'b001011;
    srl_exp = 32'h0; srl_fl = 6'b001011;
`endif
    rst = 1'b0;
    // Reset held low with random inputs: outputs stay cleared.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      alu_src_mux = 1'($urandom); alu_funct = 6'($urandom);
      reg_dst_mux = 2'($urandom); sel_j_jr = 1'($urandom);
      in_next_pc = $urandom; in_immediate = $urandom;
      in_data_rs = $urandom; in_data_rt = $urandom;
      in_rs = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
      {in_mem_write_enable, in_sel_beq_bne, in_fl_write_enable, in_sel_jt_jf,
       in_is_branch, in_is_jump, in_reg_write_enable, in_wb_res_mux} = 9'($urandom);
      @(posedge clk); #1;
      chk_all_zero($sformatf("rst_hold%0d", i));
    end

    // Release at a falling edge; the very next rising edge captures.
    @(negedge clk);
    rst = 1'b1;
    drive("add_ovf", 1, FN_ADD, 2'b00, 1, 32'h7FFFFFFF, 32'hDEAD0000, 32'h1,
          32'h80000000, 6'b101110, 5'd3, 32'h7FFFFFFF);
    @(negedge clk);
    drive("sub_zero", 0, FN_SUB, 2'b01, 0, 32'd5, 32'd5, 32'h40,
          32'h0, 6'b001011, 5'd7, 32'h40);
    @(negedge clk);
    drive("sub_borrow", 0, FN_SUB, 2'b10, 1, 32'd0, 32'd1, 32'h99,
          32'hFFFFFFFF, 6'b011110, 5'd31, 32'h0);
    @(negedge clk);
    drive("add_carry", 0, FN_ADD, 2'b11, 1, 32'hFFFFFFFF, 32'd1, 32'h5,
          32'h0, 6'b011011, 5'd0, 32'hFFFFFFFF);
    @(negedge clk);
    drive("and", 0, FN_AND, 2'b00, 1, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,
          32'h00F000F0, 6'b000010, 5'd3, 32'hF0F0F0F0);
    @(negedge clk);
    drive("or", 0, FN_OR, 2'b01, 0, 32'h000000F0, 32'h0000000F, 32'h77,
          32'h000000FF, 6'b000010, 5'd7, 32'h77);
    @(negedge clk);
    drive("xor", 0, FN_XOR, 2'b00, 1, 32'hFFFF0000, 32'hFFFFFFFF, 32'h0,
          32'h0000FFFF, 6'b000010, 5'd3, 32'hFFFF0000);
    @(negedge clk);
    drive("nor", 0, FN_NOR, 2'b00, 0, 32'h0, 32'h0, 32'h12,
          32'hFFFFFFFF, 6'b001110, 5'd3, 32'h12);
    @(negedge clk);
    drive("slt_true", 0, FN_SLT, 2'b00, 1, 32'hFFFFFFFF, 32'd1, 32'h0,
          32'h1, 6'b000010, 5'd3, 32'hFFFFFFFF);
    @(negedge clk);
    drive("slt_false", 1, FN_SLT, 2'b00, 0, 32'd5, 32'd0, 32'd3,
          32'h0, 6'b001011, 5'd3, 32'd3);
    @(negedge clk);
    drive("passb", 1, FN_PASSB, 2'b01, 0, 32'h1234, 32'h5555, 32'h40,
          32'h40, 6'b000010, 5'd7, 32'h40);
    @(negedge clk);
    drive("jr_abs", 0, FN_PASSB, 2'b01, 1, 32'h1234, 32'h5555, 32'h40,
          32'h5555, 6'b000010, 5'd7, 32'h1234);
    @(negedge clk);
    drive("sub_ovf", 1, FN_SUB, 2'b00, 0, 32'h80000000, 32'h0, 32'h1,
          32'h7FFFFFFF, 6'b100010, 5'd3, 32'h1);
    @(negedge clk);
    drive("unlisted", 0, 6'h15, 2'b00, 0, 32'hABCD, 32'h1234, 32'h8,
          32'h0, 6'b001011, 5'd3, 32'h8);
    @(negedge clk);
    drive("sra", 1, FN_SRA, 2'b00, 0, 32'h80000000, 32'h0, 32'd4,
          sra_exp, sra_fl, 5'd3, 32'd4);
    @(negedge clk);
    drive("sll", 1, FN_SLL, 2'b00, 0, 32'h1, 32'h0, 32'd4,
          sll_exp, sll_fl, 5'd3, 32'd4);
    @(negedge clk);
    drive("srl", 0, FN_SRL, 2'b00, 0, 32'h80000000, 32'd4, 32'h0,
          srl_exp, srl_fl, 5'd3, 32'h0);

    // Drain with a bound.
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #2;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end

    // Asynchronous reset mid-cycle clears at once and drops the in-flight op.
    @(negedge clk);
    drive("inflight", 1, FN_ADD, 2'b01, 1, 32'h10, 32'h20, 32'h30,
          32'h40, 6'b000010, 5'd7, 32'h10);
    sb.delete();
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk); #1;
    chk_all_zero("rst_discard");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
